// File: rtl/guess_evaluator.sv
// guess_evaluator: walks the five slots of a committed, colour-scored guess row
// one per cycle, counts greens/yellows, flags malformed rows and tracks the game
// outcome (win / lose / game_over) across rows.
// Latency: start sampled at edge N, done pulses in the cycle after edge N+6.
// busy is high from the cycle after the start edge through the done cycle.
// Starts while busy or after game over are dropped; there is no queueing.
// Optional feature macro: KEYBOARD_STATE_EN enables per-letter best-colour storage
// on letter_state; without it letter_state is tied to zero.
// Ports:
//   clk, clr (async active-high reset), start, row_in, new_game (sync clear)
//   busy, done, green_count, yellow_count, guesses_used, win, lose, game_over,
//   bad_row, letter_state
module guess_evaluator #(
  parameter int MAX_ROWS = 6,
  parameter int SLOT_W   = 7
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [5*SLOT_W-1:0]   row_in,
  input  logic                  new_game,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            green_count,
  output logic [2:0]            yellow_count,
  output logic [2:0]            guesses_used,
  output logic                  win,
  output logic                  lose,
  output logic                  game_over,
  output logic                  bad_row,
  output logic [51:0]           letter_state
);

  typedef enum logic [1:0] {IDLE, SCAN, JUDGE} state_t;

  state_t              r_state;
  logic [5*SLOT_W-1:0] r_row;
  logic [2:0]          r_idx;
  logic [2:0]          r_green;
  logic [2:0]          r_yellow;
  logic [2:0]          r_guesses;
  logic                r_win;
  logic                r_lose;
  logic                r_bad;
  logic                r_busy;
  logic                r_done;

  logic [SLOT_W-1:0]   w_slot;
  logic [4:0]          w_letter;
  logic [1:0]          w_colour;
  logic                w_valid;
  logic [2:0]          w_guesses_next;

  // Slot currently under inspection during SCAN.
  assign w_slot   = r_row[r_idx*SLOT_W +: SLOT_W];
  assign w_letter = w_slot[4:0];
  assign w_colour = w_slot[6:5];
  // A slot counts only if it was scored and holds a letter A..Z.
  assign w_valid  = (w_colour != 2'b00) && (w_letter != 5'd0) && (w_letter <= 5'd26);

  assign w_guesses_next = (r_guesses < 3'(MAX_ROWS)) ? r_guesses + 3'd1 : r_guesses;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= IDLE;
      r_row     <= '0;
      r_idx     <= '0;
      r_green   <= '0;
      r_yellow  <= '0;
      r_guesses <= '0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
      r_bad     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (new_game) begin
      // Overrides any in-flight scan and any coincident start.
      r_state   <= IDLE;
      r_idx     <= '0;
      r_green   <= '0;
      r_yellow  <= '0;
      r_guesses <= '0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
      r_bad     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (start && !(r_win || r_lose)) begin
            r_row    <= row_in;
            r_green  <= '0;
            r_yellow <= '0;
            r_bad    <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (!w_valid) begin
            r_bad <= 1'b1;
          end else if (w_colour == 2'b11) begin
            r_green <= r_green + 3'd1;
          end else if (w_colour == 2'b10) begin
            r_yellow <= r_yellow + 3'd1;
          end
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd4) begin
            r_state <= JUDGE;
          end
        end
        JUDGE: begin
          r_guesses <= w_guesses_next;
          if (r_green == 3'd5) begin
            r_win <= 1'b1;
          end else if (w_guesses_next == 3'(MAX_ROWS)) begin
            r_lose <= 1'b1;
          end
          // busy stays high through the done cycle; IDLE drops both next edge.
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef KEYBOARD_STATE_EN
  logic [51:0] r_letter_state;
  logic [4:0]  w_lidx;
  logic [1:0]  w_ls_old;

  // Letter A is index 0, so letter code n lives at bits [2(n-1) +: 2].
  assign w_lidx   = w_letter - 5'd1;
  assign w_ls_old = r_letter_state[{w_lidx, 1'b0} +: 2];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_letter_state <= '0;
    end else if (new_game) begin
      r_letter_state <= '0;
    end else if ((r_state == SCAN) && w_valid && (w_colour > w_ls_old)) begin
      r_letter_state[{w_lidx, 1'b0} +: 2] <= w_colour;
    end
  end

  assign letter_state = r_letter_state;
`else
  assign letter_state = 52'b0;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign green_count  = r_green;
  assign yellow_count = r_yellow;
  assign guesses_used = r_guesses;
  assign win          = r_win;
  assign lose         = r_lose;
  assign game_over    = r_win | r_lose;
  assign bad_row      = r_bad;

endmodule
